// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin two-port arbiter in front of the 8x32 register file.
// Define ARB_LOCK_EN to add a_lock/b_lock grant locking (up to LOCK_MAX consecutive grants).
module regfile_port_arbiter #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter bit FIRST_PRIO = 1'b0,
   parameter int LOCK_MAX   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
`ifdef ARB_LOCK_EN
   input  logic              a_lock,
   input  logic              b_lock,
`endif
   input  logic [DATA_W-1:0] rf_data_out,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] rf_address,
   output logic [DATA_W-1:0] rf_data_in,
   output logic              rf_enable
);
   typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_t;

   if (LOCK_MAX < 1) begin : g_lock_max_chk
      $error("LOCK_MAX must be at least 1");
   end

   state_t            r_state;
   state_t            w_next;
   logic              r_last;
   logic              r_a_gnt;
   logic              r_b_gnt;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_rf_address;
   logic [DATA_W-1:0] r_rf_data_in;
   logic              r_rf_enable;
   logic              w_hold_a;
   logic              w_hold_b;
   logic              w_elig_a;
   logic              w_elig_b;
   logic              w_grant;
   logic              w_pick_b;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);
   logic [CNT_W-1:0] r_lock_cnt;
   // a locked owner keeps the port while its run of grants is below the limit
   assign w_hold_a = r_state == ACC_A && a_lock && a_req && r_lock_cnt < LOCK_LIM;
   assign w_hold_b = r_state == ACC_B && b_lock && b_req && r_lock_cnt < LOCK_LIM;
   // length of the current run of consecutive grants to one port
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_lock_cnt <= '0;
      else r_lock_cnt <= w_next == IDLE ? '0 : w_next == r_state ? r_lock_cnt + CNT_W'(1) : CNT_W'(1);
`else
   assign w_hold_a = 1'b0;
   assign w_hold_b = 1'b0;
`endif

   // the port that just had an access sits out one cycle unless it holds a lock
   assign w_elig_a = a_req && (r_state != ACC_A || w_hold_a);
   assign w_elig_b = b_req && (r_state != ACC_B || w_hold_b);
   assign w_grant  = w_elig_a || w_elig_b;
   assign w_pick_b = w_hold_b || (!w_hold_a && w_elig_b && (!w_elig_a || !r_last));
   assign w_next   = !w_grant ? IDLE : w_pick_b ? ACC_B : ACC_A;

   // arbitration FSM with registered grant, regfile drive and read-data return
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last       <= ~FIRST_PRIO;
         r_a_gnt      <= 1'b0;
         r_b_gnt      <= 1'b0;
         r_a_rvalid   <= 1'b0;
         r_b_rvalid   <= 1'b0;
         r_rdata      <= '0;
         r_rf_address <= '0;
         r_rf_data_in <= '0;
         r_rf_enable  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_a_gnt     <= w_next == ACC_A;
         r_b_gnt     <= w_next == ACC_B;
         r_rf_enable <= w_grant && (w_pick_b ? b_we : a_we);
         if (w_grant) begin
            r_last       <= w_pick_b;
            r_rf_address <= w_pick_b ? b_addr : a_addr;
            r_rf_data_in <= w_pick_b ? b_wdata : a_wdata;
         end
         r_a_rvalid <= r_state == ACC_A && !r_rf_enable;
         r_b_rvalid <= r_state == ACC_B && !r_rf_enable;
         if (r_state != IDLE && !r_rf_enable) r_rdata <= rf_data_out;
      end

   assign a_gnt      = r_a_gnt;
   assign b_gnt      = r_b_gnt;
   assign a_rvalid   = r_a_rvalid;
   assign b_rvalid   = r_b_rvalid;
   assign rdata      = r_rdata;
   assign rf_address = r_rf_address;
   assign rf_data_in = r_rf_data_in;
   assign rf_enable  = r_rf_enable;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed checks of the arbiter against a behavioural 8x32 register file.
module tb_regfile_port_arbiter;
   localparam int DW = 8;
   localparam int AW = 5;
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid, rf_enable;
   logic [DW-1:0] rdata, rf_data_in, rf_data_out;
   logic [AW-1:0] rf_address;
`ifdef ARB_LOCK_EN
   logic          a_lock = 1'b0, b_lock = 1'b0;
`endif
   logic [DW-1:0] mem [32];
   int            n_chk = 0;
   int            n_pass = 0;

   regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIRST_PRIO(1'b0), .LOCK_MAX(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef ARB_LOCK_EN
      .a_lock(a_lock), .b_lock(b_lock),
`endif
      .rf_data_out(rf_data_out),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .rdata(rdata), .rf_address(rf_address), .rf_data_in(rf_data_in), .rf_enable(rf_enable)
   );

   always #5 clk = ~clk;

   // register file: $sp (r29) powers up as 0xFF, the rest as 0; writes land on negedge
   assign rf_data_out = mem[rf_address];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 8'hFF : 8'h00;
      forever begin
         @(negedge clk);
         if (rf_enable) mem[rf_address] = rf_data_in;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      // reset held with a pending request: everything quiet
      a_req = 1'b1;
      step();
      step();
      check("rst_a_gnt", a_gnt, 0);
      check("rst_b_gnt", b_gnt, 0);
      check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rf_addr", rf_address, 0);
      check("rst_rf_din", rf_data_in, 0);
      check("rst_rf_en", rf_enable, 0);
      reset_n = 1'b1;
      step();
      check("rel_a_gnt", a_gnt, 1);
      a_req = 1'b0;
      step();
      check("rel_a_rvalid", a_rvalid, 1);
      check("rel_a_gnt_drop", a_gnt, 0);
      check("rel_rdata", rdata, 8'h00);
      step();

      // A writes r5=0x3C, then reads it back
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 8'h3C;
      step();
      check("wr_a_gnt", a_gnt, 1);
      check("wr_rf_en", rf_enable, 1);
      check("wr_rf_addr", rf_address, 5);
      check("wr_rf_din", rf_data_in, 8'h3C);
      a_we = 1'b0;
      step();
      check("wr_gap_gnt", a_gnt, 0);
      check("wr_no_rvalid", a_rvalid, 0);
      step();
      check("rd_a_gnt", a_gnt, 1);
      check("rd_rf_en", rf_enable, 0);
      a_req = 1'b0;
      step();
      check("rd_a_rvalid", a_rvalid, 1);
      check("rd_rdata", rdata, 8'h3C);
      step();
      check("rd_rvalid_pulse", a_rvalid, 0);

      // A reads r29, B reads r1, both continuously from reset
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd29;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         check("alt_a_gnt", a_gnt, (i % 2 == 0) ? 1 : 0);
         check("alt_b_gnt", b_gnt, (i % 2 == 1) ? 1 : 0);
         if (i > 0) begin
            check("alt_rdata", rdata, (i % 2 == 1) ? 8'hFF : 8'h00);
            check("alt_rvalid", {a_rvalid, b_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
         end
      end
      a_req = 1'b0; b_req = 1'b0;
      step();
      step();

      // simultaneous writes to r3 after reset: A first, B second
      a_req = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 8'h11;
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd3; b_wdata = 8'h22;
      do_reset();
      step();
      check("ww_a_first", {a_gnt, b_gnt}, 2'b10);
      check("ww_a_din", rf_data_in, 8'h11);
      a_req = 1'b0;
      step();
      check("ww_b_next", {a_gnt, b_gnt}, 2'b01);
      check("ww_b_din", rf_data_in, 8'h22);
      b_req = 1'b0;
      step();
      check("ww_no_rvalid", {a_rvalid, b_rvalid}, 0);
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd3;
      step();
      a_req = 1'b0;
      step();
      check("ww_rd_r3", rdata, 8'h22);
      step();

      // reset during B write of r7 before its negedge: write lost, no rvalid
      b_req = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 8'h55;
      step();
      check("mid_b_gnt", b_gnt, 1);
      check("mid_rf_en", rf_enable, 1);
      reset_n = 1'b0;
      b_req = 1'b0;
      #1;
      check("mid_rf_en_drop", rf_enable, 0);
      check("mid_b_gnt_drop", b_gnt, 0);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_b_rvalid", b_rvalid, 0);
      end
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd7;
      step();
      a_req = 1'b0;
      step();
      check("mid_r7_rvalid", a_rvalid, 1);
      check("mid_r7_kept", rdata, 8'h00);
      step();

`ifdef ARB_LOCK_EN
      // A locks while B keeps requesting: four A grants, then B
      a_req = 1'b1; a_we = 1'b0; a_addr = 5'd0; a_lock = 1'b1;
      b_req = 1'b1; b_we = 1'b0; b_addr = 5'd1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         check("lock_gnts", {a_gnt, b_gnt}, (i < 4) ? 2'b10 : 2'b01);
      end
      a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
      step();
      step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
